bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 175 +++++++++++++++++
 tb/tb_bus_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-master Wishbone arbiter: alternating priority on simultaneous requests, one idle
// cycle between owners, and a watchdog that aborts transfers the slaves never answer.
module bus_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        CLK_I,
    input  logic        reset,

    input  logic [29:0] m0_ADR_I,
    input  logic        m0_CYC_I,
    input  logic        m0_STB_I,
    input  logic        m0_WE_I,
    input  logic [3:0]  m0_SEL_I,
    input  logic [31:0] m0_DAT_I,
    output logic [31:0] m0_DAT_O,
    output logic        m0_ACK_O,
    output logic        m0_RTY_O,
    output logic        m0_ERR_O,
    input  logic        m0_cpu_space_I,

    input  logic [29:0] m1_ADR_I,
    input  logic        m1_CYC_I,
    input  logic        m1_STB_I,
    input  logic        m1_WE_I,
    input  logic [3:0]  m1_SEL_I,
    input  logic [31:0] m1_DAT_I,
    output logic [31:0] m1_DAT_O,
    output logic        m1_ACK_O,
    output logic        m1_RTY_O,
    output logic        m1_ERR_O,

    output logic [29:0] s_ADR_O,
    output logic        s_CYC_O,
    output logic        s_STB_O,
    output logic        s_WE_O,
    output logic [3:0]  s_SEL_O,
    output logic [31:0] s_DAT_O,
    output logic        s_cpu_space_O,
    input  logic [31:0] s_DAT_I,
    input  logic        s_ACK_I,
    input  logic        s_RTY_I,
    input  logic        s_ERR_I,

    output logic [1:0]  gnt_O
);

    typedef enum logic [2:0] {IDLE, GNT0, GNT1, ABORT, DROP} state_t;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t      state_reg;
    logic        last_reg;
    logic [7:0]  wd_reg;
    logic [1:0]  gnt_reg;

    logic [1:0]  m_cyc;
    logic [1:0]  m_stb;
    logic [1:0]  m_we;
    logic [1:0]  m_cs;
    logic [29:0] m_adr [2];
    logic [3:0]  m_sel [2];
    logic [31:0] m_dat [2];

    logic        granted;
    logic        slv_term;
    logic [1:0]  ack_vec;
    logic [1:0]  rty_vec;
    logic [1:0]  err_vec;

    assign m_cyc    = {m1_CYC_I, m0_CYC_I};
    assign m_stb    = {m1_STB_I, m0_STB_I};
    assign m_we     = {m1_WE_I, m0_WE_I};
    assign m_cs     = {1'b0, m0_cpu_space_I};
    assign m_adr[0] = m0_ADR_I;
    assign m_adr[1] = m1_ADR_I;
    assign m_sel[0] = m0_SEL_I;
    assign m_sel[1] = m1_SEL_I;
    assign m_dat[0] = m0_DAT_I;
    assign m_dat[1] = m1_DAT_I;

    // last_reg is written on every grant, so it also names the owner in GNTx, ABORT and DROP.
    assign granted  = (state_reg == GNT0) || (state_reg == GNT1);
    assign slv_term = s_ACK_I | s_RTY_I | s_ERR_I;
    assign gnt_O    = gnt_reg;
    assign m0_DAT_O = s_DAT_I;
    assign m1_DAT_O = s_DAT_I;

    always_comb begin
        s_ADR_O       = '0;
        s_CYC_O       = 1'b0;
        s_STB_O       = 1'b0;
        s_WE_O        = 1'b0;
        s_SEL_O       = '0;
        s_DAT_O       = '0;
        s_cpu_space_O = 1'b0;
        if (granted) begin
            s_ADR_O       = m_adr[last_reg];
            s_CYC_O       = m_cyc[last_reg];
            s_STB_O       = m_stb[last_reg];
            s_WE_O        = m_we[last_reg];
            s_SEL_O       = m_sel[last_reg];
            s_DAT_O       = m_dat[last_reg];
            s_cpu_space_O = m_cs[last_reg];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_term
            logic owns;
            assign owns        = (last_reg == 1'(gi));
            assign ack_vec[gi] = granted & owns & s_ACK_I;
            assign rty_vec[gi] = granted & owns & s_RTY_I;
            assign err_vec[gi] = owns & ((granted & s_ERR_I) | (state_reg == ABORT));
        end
    endgenerate

    assign m0_ACK_O = ack_vec[0];
    assign m0_RTY_O = rty_vec[0];
    assign m0_ERR_O = err_vec[0];
    assign m1_ACK_O = ack_vec[1];
    assign m1_RTY_O = rty_vec[1];
    assign m1_ERR_O = err_vec[1];

    always_ff @(posedge CLK_I) begin
        if (reset) begin
            state_reg <= IDLE;
            last_reg  <= 1'b1;
            wd_reg    <= '0;
            gnt_reg   <= '0;
        end else begin
            wd_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (m_cyc[0] && (!m_cyc[1] || last_reg)) begin
                        state_reg <= GNT0;
                        last_reg  <= 1'b0;
                        gnt_reg   <= 2'b01;
                    end else if (m_cyc[1]) begin
                        state_reg <= GNT1;
                        last_reg  <= 1'b1;
                        gnt_reg   <= 2'b10;
                    end
                end
                GNT0, GNT1: begin
                    if (!m_cyc[last_reg]) begin
                        state_reg <= IDLE;
                        gnt_reg   <= '0;
                    end else if (m_stb[last_reg] && !slv_term) begin
                        // A termination in the final watchdog cycle wins over the abort.
                        if (wd_reg == WD_LAST) begin
                            state_reg <= ABORT;
                            gnt_reg   <= '0;
                        end else begin
                            wd_reg <= wd_reg + 8'd1;
                        end
                    end
                end
                ABORT: begin
                    state_reg <= m_cyc[last_reg] ? DROP : IDLE;
                end
                DROP: begin
                    if (!m_cyc[last_reg]) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    gnt_reg   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Cycle-by-cycle vector bench for bus_arbiter with a short watchdog (TIMEOUT = 4).
module tb_bus_arbiter;

    localparam logic [29:0] M0_ADR = 30'h3FFF_FFF8;
    localparam logic [29:0] M1_ADR = 30'h0000_0200;
    localparam logic [3:0]  M0_SEL = 4'hF;
    localparam logic [3:0]  M1_SEL = 4'h3;
    localparam logic [31:0] M0_DAT = 32'h1111_2222;
    localparam logic [31:0] M1_DAT = 32'h3333_4444;

    typedef struct {
        logic       rst;
        logic       c0, s0, cs0;
        logic       c1, s1;
        logic       ack, rty, err;
        logic [1:0] own;    // expected bus owner, one-hot (00 = bus parked)
        logic       gx;     // grant not checked this cycle
        logic [2:0] t0;     // expected {ACK,RTY,ERR} to m0
        logic [2:0] t1;     // expected {ACK,RTY,ERR} to m1
    } vec_t;

    logic        clk;
    logic        reset;
    logic [29:0] m0_ADR_I, m1_ADR_I, s_ADR_O;
    logic        m0_CYC_I, m0_STB_I, m0_WE_I, m0_cpu_space_I;
    logic        m1_CYC_I, m1_STB_I, m1_WE_I;
    logic [3:0]  m0_SEL_I, m1_SEL_I, s_SEL_O;
    logic [31:0] m0_DAT_I, m1_DAT_I, m0_DAT_O, m1_DAT_O, s_DAT_O, s_DAT_I;
    logic        m0_ACK_O, m0_RTY_O, m0_ERR_O, m1_ACK_O, m1_RTY_O, m1_ERR_O;
    logic        s_CYC_O, s_STB_O, s_WE_O, s_cpu_space_O;
    logic        s_ACK_I, s_RTY_I, s_ERR_I;
    logic [1:0]  gnt_O;

    vec_t        exp_q[$];
    vec_t        tbl[$];
    int          errors = 0;
    int          checks = 0;
    int          idx = 0;
    logic [31:0] sdat;

    bus_arbiter #(.TIMEOUT(4)) dut (
        .CLK_I(clk), .reset(reset),
        .m0_ADR_I(m0_ADR_I), .m0_CYC_I(m0_CYC_I), .m0_STB_I(m0_STB_I), .m0_WE_I(m0_WE_I),
        .m0_SEL_I(m0_SEL_I), .m0_DAT_I(m0_DAT_I), .m0_DAT_O(m0_DAT_O),
        .m0_ACK_O(m0_ACK_O), .m0_RTY_O(m0_RTY_O), .m0_ERR_O(m0_ERR_O),
        .m0_cpu_space_I(m0_cpu_space_I),
        .m1_ADR_I(m1_ADR_I), .m1_CYC_I(m1_CYC_I), .m1_STB_I(m1_STB_I), .m1_WE_I(m1_WE_I),
        .m1_SEL_I(m1_SEL_I), .m1_DAT_I(m1_DAT_I), .m1_DAT_O(m1_DAT_O),
        .m1_ACK_O(m1_ACK_O), .m1_RTY_O(m1_RTY_O), .m1_ERR_O(m1_ERR_O),
        .s_ADR_O(s_ADR_O), .s_CYC_O(s_CYC_O), .s_STB_O(s_STB_O), .s_WE_O(s_WE_O),
        .s_SEL_O(s_SEL_O), .s_DAT_O(s_DAT_O), .s_cpu_space_O(s_cpu_space_O),
        .s_DAT_I(s_DAT_I), .s_ACK_I(s_ACK_I), .s_RTY_I(s_RTY_I), .s_ERR_I(s_ERR_I),
        .gnt_O(gnt_O)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic c0, input logic s0, input logic cs0,
                                input logic c1, input logic s1, input logic ack, input logic rty,
                                input logic err, input logic [1:0] own, input logic gx,
                                input logic [2:0] t0, input logic [2:0] t1);
        vec_t v;
        v.rst = rst; v.c0 = c0; v.s0 = s0; v.cs0 = cs0; v.c1 = c1; v.s1 = s1;
        v.ack = ack; v.rty = rty; v.err = err; v.own = own; v.gx = gx; v.t0 = t0; v.t1 = t1;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [68:0] act, input logic [68:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic check_outputs();
        vec_t        e;
        logic [68:0] eb;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard step %0d: got empty queue expected one entry", idx);
            return;
        end
        e  = exp_q.pop_front();
        eb = '0;
        if (e.own == 2'b01)
            eb = {M0_ADR, M0_SEL, M0_DAT, 1'b0, e.c0, e.s0, e.cs0};
        else if (e.own == 2'b10)
            eb = {M1_ADR, M1_SEL, M1_DAT, 1'b1, e.c1, e.s1, 1'b0};
        if (!e.gx)
            cmp("gnt", 69'(gnt_O), 69'(e.own));
        cmp("bus", {s_ADR_O, s_SEL_O, s_DAT_O, s_WE_O, s_CYC_O, s_STB_O, s_cpu_space_O}, eb);
        cmp("m0_term", 69'({m0_ACK_O, m0_RTY_O, m0_ERR_O}), 69'(e.t0));
        cmp("m1_term", 69'({m1_ACK_O, m1_RTY_O, m1_ERR_O}), 69'(e.t1));
        cmp("rdata", 69'({m0_DAT_O, m1_DAT_O}), 69'({sdat, sdat}));
        $display("step %0d: rst=%b gnt=%b s_cyc=%b s_stb=%b s_cpu=%b m0_are=%b%b%b m1_are=%b%b%b",
                 idx, e.rst, gnt_O, s_CYC_O, s_STB_O, s_cpu_space_O,
                 m0_ACK_O, m0_RTY_O, m0_ERR_O, m1_ACK_O, m1_RTY_O, m1_ERR_O);
    endtask

    task automatic step(input vec_t v);
        @(posedge clk);
        #1;
        idx++;
        reset          = v.rst;
        m0_CYC_I       = v.c0;
        m0_STB_I       = v.s0;
        m0_cpu_space_I = v.cs0;
        m1_CYC_I       = v.c1;
        m1_STB_I       = v.s1;
        s_ACK_I        = v.ack;
        s_RTY_I        = v.rty;
        s_ERR_I        = v.err;
        sdat           = 32'hA5A5_0000 | 32'(idx);
        s_DAT_I        = sdat;
        exp_q.push_back(v);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        reset = 1'b1;
        m0_ADR_I = M0_ADR; m0_SEL_I = M0_SEL; m0_DAT_I = M0_DAT; m0_WE_I = 1'b0;
        m1_ADR_I = M1_ADR; m1_SEL_I = M1_SEL; m1_DAT_I = M1_DAT; m1_WE_I = 1'b1;
        m0_CYC_I = 1'b0; m0_STB_I = 1'b0; m0_cpu_space_I = 1'b0;
        m1_CYC_I = 1'b0; m1_STB_I = 1'b0;
        s_ACK_I = 1'b0; s_RTY_I = 1'b0; s_ERR_I = 1'b0;
        sdat = 32'h0; s_DAT_I = 32'h0;

        //                rst c0 s0 cs c1 s1 ak ry er own   gx  t0      t1
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 3'b000, 3'b000)); // reset state
        tbl.push_back(mk(0, 1, 1, 0, 1, 1, 0, 0, 0, 2'b00, 0, 3'b000, 3'b000)); // both request
        tbl.push_back(mk(0, 1, 1, 0, 1, 1, 1, 0, 0, 2'b01, 0, 3'b100, 3'b000)); // m0 wins, ACK
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 2'b01, 0, 3'b000, 3'b000)); // m0 drops CYC
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 0, 3'b000, 3'b000)); // idle gap
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 2'b10, 0, 3'b000, 3'b100)); // m1 served
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 3'b000, 3'b000));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 0, 3'b000, 3'b000)); // m1 alone
        tbl.push_back(mk(0, 1, 1, 0, 1, 1, 0, 1, 0, 2'b10, 0, 3'b000, 3'b010)); // RTY to m1, m0 waits
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b10, 0, 3'b000, 3'b000)); // m1 drops
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 3'b000, 3'b000)); // idle gap
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1, 0, 0, 2'b01, 0, 3'b100, 3'b000)); // m0 granted
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 3'b000, 3'b000));
        tbl.push_back(mk(0, 1, 1, 0, 1, 1, 0, 0, 0, 2'b00, 0, 3'b000, 3'b000)); // both, last = m0
        tbl.push_back(mk(0, 1, 1, 0, 1, 1, 1, 0, 0, 2'b10, 0, 3'b000, 3'b100)); // m1 wins
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b10, 0, 3'b000, 3'b000));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 3'b000, 3'b000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 3'b000, 3'b000)); // granted, CYC gone
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 3'b000, 3'b000)); // cpu_space request
        tbl.push_back(mk(0, 1, 1, 1, 1, 1, 0, 1, 0, 2'b01, 0, 3'b010, 3'b000)); // RTY on IACK cycle
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 2'b01, 0, 3'b000, 3'b000));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0, 0, 2'b00, 0, 3'b000, 3'b000)); // stray cpu_space idle
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b10, 0, 3'b000, 3'b000)); // cpu_space hidden for m1
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 3'b000, 3'b000));

        repeat (2) @(posedge clk);
        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Watchdog abort: four unanswered strobes, ERR in the fifth, then DROP for two cycles.
        step(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 3'b000, 3'b000));
        for (int i = 0; i < 4; i++) step(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b01, 0, 3'b000, 3'b000));
        step(mk(0, 1, 1, 0, 0, 0, 1, 0, 0, 2'b00, 1, 3'b001, 3'b000)); // ABORT, slave ACK ignored
        step(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 1, 3'b000, 3'b000)); // DROP
        step(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 1, 3'b000, 3'b000)); // DROP, m0 lets go
        step(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 0, 3'b000, 3'b000)); // IDLE
        step(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b10, 0, 3'b000, 3'b000));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 3'b000, 3'b000));

        // ACK in the last watchdog cycle beats the abort.
        step(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 3'b000, 3'b000));
        for (int i = 0; i < 3; i++) step(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b01, 0, 3'b000, 3'b000));
        step(mk(0, 1, 1, 0, 0, 0, 1, 0, 0, 2'b01, 0, 3'b100, 3'b000));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 3'b000, 3'b000));

        // STB gap with CYC held keeps ownership and restarts the watchdog.
        step(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 3'b000, 3'b000));
        for (int i = 0; i < 3; i++) step(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b01, 0, 3'b000, 3'b000));
        step(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 3'b000, 3'b000));
        for (int i = 0; i < 3; i++) step(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b01, 0, 3'b000, 3'b000));
        step(mk(0, 1, 1, 0, 0, 0, 1, 0, 0, 2'b01, 0, 3'b100, 3'b000));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 3'b000, 3'b000));

        // Reset in the middle of an m1 transfer, then in the middle of an m0 transfer.
        step(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 0, 3'b000, 3'b000));
        step(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 2'b10, 0, 3'b000, 3'b000));
        step(mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 2'b10, 0, 3'b000, 3'b000)); // reset sampled this edge
        step(mk(0, 1, 1, 0, 1, 1, 0, 0, 0, 2'b00, 0, 3'b000, 3'b000)); // parked, both request
        step(mk(0, 1, 1, 0, 1, 1, 0, 0, 0, 2'b01, 0, 3'b000, 3'b000)); // m0 wins
        step(mk(1, 1, 1, 0, 1, 1, 0, 0, 0, 2'b01, 0, 3'b000, 3'b000)); // reset while m0 owns
        step(mk(0, 1, 1, 0, 1, 1, 0, 0, 0, 2'b00, 0, 3'b000, 3'b000));
        step(mk(0, 1, 1, 0, 1, 1, 1, 0, 0, 2'b01, 0, 3'b100, 3'b000)); // last back to 1: m0 wins
        step(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 2'b01, 0, 3'b000, 3'b000));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 3'b000, 3'b000));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 3'b000, 3'b000));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
